tick_scheduler: RTL and testbench

- Run-time controller for the board's clock-division resource.
- Owns a programmable prescaler and sequences it through start/stop and one-shot/continuous modes.
- Accepts new divide ratios over a valid/ready handshake and applies them only at period boundaries.
- Emits a one-cycle tick enable plus a divided square wave for the display and sampling logic; downstream logic uses tick as a clock enable, never as a clock.

---
 rtl/tick_scheduler_if.sv | 23 ++
 rtl/tick_scheduler.sv | 130 +++++++++++++
 tb/tb_tick_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - Configuration handshake bundle for tick_scheduler
interface tick_scheduler_if #(
  parameter int DIV_WIDTH = 32
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic                 cfg_oneshot;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_oneshot,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_oneshot,
    output cfg_ready
  );
endinterface

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - Programmable prescaler with start/stop, one-shot and boundary-aligned reconfiguration
module tick_scheduler #(
  parameter int DIV_WIDTH   = 32,
  parameter int DEFAULT_DIV = 25000,
  parameter int TCNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  tick_scheduler_if.slave       i_cfg,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic                  o_tick,
  output logic                  o_clk_div,
  output logic                  o_busy,
  output logic [TCNT_WIDTH-1:0] o_tick_count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int             DEF_DIV_CLAMPED = (DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV;
  localparam logic [DIV_WIDTH-1:0] DEF_DIV   = DIV_WIDTH'(DEF_DIV_CLAMPED);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

  logic [0:0]            r_state;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_oneshot;
  logic [DIV_WIDTH-1:0]  r_count;
  logic                  r_pend_valid;
  logic [DIV_WIDTH-1:0]  r_pend_div;
  logic                  r_pend_oneshot;
  logic                  r_ready;
  logic                  r_tick;
  logic                  r_clk_div;
  logic [TCNT_WIDTH-1:0] r_tick_count;

  logic                  w_run;
  logic                  w_xfer;
  logic [DIV_WIDTH-1:0]  w_new_div;
  logic                  w_tc;
  logic                  w_stop;
  logic                  w_fire;
  logic                  w_boundary;

  assign w_run      = (r_state == S_RUN);
  assign w_xfer     = i_cfg.cfg_valid && r_ready;
  assign w_new_div  = (i_cfg.cfg_div == '0) ? DIV_ONE : i_cfg.cfg_div;
  assign w_tc       = w_run && (r_count == (r_div - DIV_ONE));
  assign w_stop     = w_run && i_stop;
  // Stop overrides a coinciding terminal count, so no tick on that edge.
  assign w_fire     = w_tc && !i_stop;
  assign w_boundary = w_tc || w_stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start && !i_stop) r_state <= S_RUN;
        S_RUN:   if (i_stop || (w_tc && r_oneshot)) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!w_run || i_stop || w_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + DIV_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick       <= 1'b0;
      r_clk_div    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_tick <= w_fire;
      if (w_fire) begin
        r_clk_div    <= ~r_clk_div;
        r_tick_count <= r_tick_count + TCNT_WIDTH'(1);
      end
    end
  end

  // A transfer landing on a boundary edge bypasses the pending slot entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div          <= DEF_DIV;
      r_oneshot      <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_pend_div     <= DEF_DIV;
      r_pend_oneshot <= 1'b0;
      r_ready        <= 1'b1;
    end else if (!w_run) begin
      if (w_xfer) begin
        r_div     <= w_new_div;
        r_oneshot <= i_cfg.cfg_oneshot;
      end
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_boundary) begin
      if (w_xfer) begin
        r_div     <= w_new_div;
        r_oneshot <= i_cfg.cfg_oneshot;
      end else if (r_pend_valid) begin
        r_div     <= r_pend_div;
        r_oneshot <= r_pend_oneshot;
      end
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_xfer) begin
      r_pend_div     <= w_new_div;
      r_pend_oneshot <= i_cfg.cfg_oneshot;
      r_pend_valid   <= 1'b1;
      r_ready        <= 1'b0;
    end
  end

  assign i_cfg.cfg_ready = r_ready;
  assign o_tick          = r_tick;
  assign o_clk_div       = r_clk_div;
  assign o_busy          = (r_state == S_RUN);
  assign o_tick_count    = r_tick_count;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - Scoreboard bench for tick_scheduler
`timescale 1ns/1ps
module tb_tick_scheduler;

  localparam int DW = 32;
  localparam int TW = 16;

  typedef struct {
    int            cyc;
    logic [TW-1:0] tcnt;
    logic          clkdiv;
  } tick_ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_stop;
  logic          o_tick;
  logic          o_clk_div;
  logic          o_busy;
  logic [TW-1:0] o_tick_count;

  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  tick_ev_t      sb[$];
  logic [TW-1:0] m_tcnt;
  logic          m_clk;

  tick_scheduler_if #(.DIV_WIDTH(DW)) cfg_if ();

  tick_scheduler #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(25000),
    .TCNT_WIDTH (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg       (cfg_if),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .o_tick      (o_tick),
    .o_clk_div   (o_clk_div),
    .o_busy      (o_busy),
    .o_tick_count(o_tick_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_tick(input int at);
    tick_ev_t e;
    m_tcnt   = m_tcnt + 1'b1;
    m_clk    = ~m_clk;
    e.cyc    = at;
    e.tcnt   = m_tcnt;
    e.clkdiv = m_clk;
    sb.push_back(e);
  endtask

  task automatic watch(input int n);
    tick_ev_t e;
    for (int k = 0; k < n; k++) begin
      step();
      if (o_tick) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick actual=tick at cycle %0d required=no tick", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL tick_cycle actual=%0d required=%0d", cyc, e.cyc);
          end
          checks++;
          if (o_tick_count !== e.tcnt) begin
            errors++;
            $display("FAIL tick_count actual=%0d required=%0d", o_tick_count, e.tcnt);
          end
          checks++;
          if (o_clk_div !== e.clkdiv) begin
            errors++;
            $display("FAIL clk_div_at_tick actual=%0b required=%0b", o_clk_div, e.clkdiv);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_ticks actual=%0d outstanding required=0 (next expected cycle %0d)",
               name, sb.size(), sb[0].cyc);
      sb.delete();
    end
  endtask

  task automatic send_cfg(input logic [DW-1:0] d, input logic os);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_div     = d;
    cfg_if.cfg_oneshot = os;
    step();
    cfg_if.cfg_valid   = 1'b0;
  endtask

  task automatic do_start(output int e0);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    e0 = cyc;
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div = '0;
    cfg_if.cfg_oneshot = 1'b0;
    step();
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL reset_tick actual=%0b required=0", o_tick); end
    checks++; if (o_clk_div !== 1'b0) begin errors++; $display("FAIL reset_clk_div actual=%0b required=0", o_clk_div); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%0b required=0", o_busy); end
    checks++; if (o_tick_count !== 16'd0) begin errors++; $display("FAIL reset_tick_count actual=%0d required=0", o_tick_count); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready actual=%0b required=1", cfg_if.cfg_ready); end
    rst = 1'b0;
    m_tcnt = '0;
    m_clk = 1'b0;
    step();
  endtask

  task automatic test_continuous();
    int e0;
    send_cfg(32'd4, 1'b0);
    do_start(e0);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL cont_busy actual=%0b required=1", o_busy); end
    expect_tick(e0 + 4);
    expect_tick(e0 + 8);
    expect_tick(e0 + 12);
    watch(12);
    drain("cont");
    do_stop();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cont_stop_busy actual=%0b required=0", o_busy); end
    checks++; if (o_tick_count !== m_tcnt) begin errors++; $display("FAIL cont_hold_count actual=%0d required=%0d", o_tick_count, m_tcnt); end
    checks++; if (o_clk_div !== m_clk) begin errors++; $display("FAIL cont_hold_clk_div actual=%0b required=%0b", o_clk_div, m_clk); end
  endtask

  task automatic test_oneshot();
    int e0;
    send_cfg(32'd5, 1'b1);
    do_start(e0);
    expect_tick(e0 + 5);
    watch(5);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy actual=%0b required=0", o_busy); end
    watch(20);
    drain("oneshot");
    checks++; if (o_tick_count !== m_tcnt) begin errors++; $display("FAIL oneshot_count actual=%0d required=%0d", o_tick_count, m_tcnt); end
  endtask

  task automatic test_reconfig();
    int e0;
    send_cfg(32'd4, 1'b0);
    do_start(e0);
    expect_tick(e0 + 4);
    expect_tick(e0 + 6);
    expect_tick(e0 + 8);
    expect_tick(e0 + 10);
    watch(2);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 32'd2;
    cfg_if.cfg_oneshot = 1'b0;
    watch(1);
    cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL reconfig_ready_low actual=%0b required=0", cfg_if.cfg_ready); end
    watch(1);
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reconfig_ready_back actual=%0b required=1", cfg_if.cfg_ready); end
    watch(6);
    drain("reconfig");
    do_stop();
  endtask

  task automatic test_boundary_xfer();
    int e0;
    send_cfg(32'd4, 1'b0);
    do_start(e0);
    expect_tick(e0 + 4);
    expect_tick(e0 + 7);
    expect_tick(e0 + 10);
    watch(3);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div = 32'd3;
    watch(1);
    cfg_if.cfg_valid = 1'b0;
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL boundary_ready actual=%0b required=1", cfg_if.cfg_ready); end
    watch(6);
    drain("boundary");
    do_stop();
  endtask

  task automatic test_div_zero();
    int e0;
    send_cfg(32'd0, 1'b0);
    do_start(e0);
    for (int k = 1; k <= 6; k++) expect_tick(e0 + k);
    watch(6);
    drain("div_zero");
    checks++; if (o_tick !== 1'b1) begin errors++; $display("FAIL div_zero_tick_held actual=%0b required=1", o_tick); end
    do_stop();
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL div_zero_stop_tick actual=%0b required=0", o_tick); end
    checks++; if (o_clk_div !== m_clk) begin errors++; $display("FAIL div_zero_clk_div actual=%0b required=%0b", o_clk_div, m_clk); end
  endtask

  task automatic test_stop_tc();
    int e0;
    send_cfg(32'd3, 1'b0);
    do_start(e0);
    expect_tick(e0 + 3);
    watch(5);
    drain("stop_tc");
    i_stop = 1'b1;
    watch(1);
    i_stop = 1'b0;
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL stop_tc_tick actual=%0b required=0", o_tick); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_tc_busy actual=%0b required=0", o_busy); end
    checks++; if (o_clk_div !== m_clk) begin errors++; $display("FAIL stop_tc_clk_div actual=%0b required=%0b", o_clk_div, m_clk); end
    checks++; if (o_tick_count !== m_tcnt) begin errors++; $display("FAIL stop_tc_count actual=%0d required=%0d", o_tick_count, m_tcnt); end
    i_start = 1'b1;
    i_stop = 1'b1;
    step();
    i_start = 1'b0;
    i_stop = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle actual=%0b required=0", o_busy); end
    watch(5);
  endtask

  task automatic test_reset_mid();
    int e0;
    send_cfg(32'd6, 1'b0);
    do_start(e0);
    expect_tick(e0 + 6);
    expect_tick(e0 + 12);
    expect_tick(e0 + 18);
    watch(20);
    drain("pre_reset");
    #2 rst = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy actual=%0b required=0", o_busy); end
    checks++; if (o_clk_div !== 1'b0) begin errors++; $display("FAIL mid_reset_clk_div actual=%0b required=0", o_clk_div); end
    checks++; if (o_tick_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count actual=%0d required=0", o_tick_count); end
    checks++; if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready actual=%0b required=1", cfg_if.cfg_ready); end
    @(negedge clk);
    rst = 1'b0;
    m_tcnt = '0;
    m_clk = 1'b0;
    step();
    do_start(e0);
    expect_tick(e0 + 25000);
    watch(25000);
    drain("default_div");
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL default_div_busy actual=%0b required=1", o_busy); end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_oneshot();
    test_reconfig();
    test_boundary_xfer();
    test_div_zero();
    test_stop_tc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
